imem_loader: RTL and testbench

//  Writer side of the byte-addressed instruction memory. Receives a program image as a

---
 rtl/imem_loader.sv | 125 ++++++++++++
 tb/tb_imem_loader.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/imem_loader.sv
// Instruction-memory loader: accepts a length-prefixed, checksummed byte stream,
// writes the payload to ascending byte addresses and holds the CPU until it verifies.
module imem_loader #(
   parameter int unsigned          ADDR_W    = 32,
   parameter int unsigned          DEPTH     = 4096,
   parameter logic [ADDR_W-1:0]    BASE_ADDR = '0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              in_valid,
   input  logic [7:0]        in_data,
   output logic              in_ready,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [7:0]        mem_wdata,
   output logic              cpu_hold,
   output logic              busy,
   output logic              done,
   output logic              error,
   output logic [ADDR_W-1:0] byte_count
);

   typedef enum logic [2:0] {
      S_IDLE, S_LEN, S_DATA, S_CSUM, S_DONE, S_ERR
   } state_t;

   state_t            state_q, state_d;
   logic [31:0]       len_q, len_d;
   logic [1:0]        hcnt_q, hcnt_d;
   logic [7:0]        sum_q, sum_d;
   logic [ADDR_W-1:0] cnt_q, cnt_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [7:0]        wdata_q, wdata_d;
   logic              we_q, we_d;

   logic              take;
   logic [31:0]       len_shift;
   logic [ADDR_W-1:0] cnt_inc;

   assign take      = in_valid & in_ready;
   assign len_shift = {len_q[23:0], in_data};
   assign cnt_inc   = cnt_q + ADDR_W'(1);

   always_comb begin
      state_d = state_q;
      len_d   = len_q;
      hcnt_d  = hcnt_q;
      sum_d   = sum_q;
      cnt_d   = cnt_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      we_d    = 1'b0;
      case (state_q)
         S_IDLE, S_DONE, S_ERR: begin
            if (start) begin
               state_d = S_LEN;
               len_d   = '0;
               hcnt_d  = '0;
               sum_d   = '0;
               cnt_d   = '0;
            end
         end
         S_LEN: begin
            if (take) begin
               len_d  = len_shift;
               hcnt_d = hcnt_q + 2'd1;
               // Decide on the fully assembled length at the edge of the 4th byte.
               if (hcnt_q == 2'd3) begin
                  if (len_shift > DEPTH || len_shift[1:0] != 2'b00) state_d = S_ERR;
                  else if (len_shift == 32'd0)                        state_d = S_CSUM;
                  else                                                 state_d = S_DATA;
               end
            end
         end
         S_DATA: begin
            if (take) begin
               we_d    = 1'b1;
               addr_d  = BASE_ADDR + cnt_q;
               wdata_d = in_data;
               sum_d   = sum_q + in_data;
               cnt_d   = cnt_inc;
               if (cnt_inc == ADDR_W'(len_q)) state_d = S_CSUM;
            end
         end
         S_CSUM: begin
            if (take) state_d = ((sum_q + in_data) == 8'd0) ? S_DONE : S_ERR;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         len_q   <= '0;
         hcnt_q  <= '0;
         sum_q   <= '0;
         cnt_q   <= '0;
         addr_q  <= '0;
         wdata_q <= '0;
         we_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         len_q   <= len_d;
         hcnt_q  <= hcnt_d;
         sum_q   <= sum_d;
         cnt_q   <= cnt_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         we_q    <= we_d;
      end
   end

   assign in_ready   = (state_q == S_LEN) || (state_q == S_DATA) || (state_q == S_CSUM);
   assign busy       = in_ready;
   assign done       = (state_q == S_DONE);
   assign error      = (state_q == S_ERR);
   assign cpu_hold   = (state_q != S_DONE);
   assign mem_we     = we_q;
   assign mem_addr   = addr_q;
   assign mem_wdata  = wdata_q;
   assign byte_count = cnt_q;

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: table of frames, hand-written corner sequences
// and random frames checked against a frame-level reference model.
module tb_imem_loader;

   localparam int unsigned DEPTH = 4096;
   localparam logic [31:0] BASE  = 32'h0;

   logic        clk = 1'b0;
   logic        rst, start, in_valid;
   logic [7:0]  in_data;
   logic        in_ready, mem_we, cpu_hold, busy, done, error;
   logic [31:0] mem_addr, byte_count;
   logic [7:0]  mem_wdata;

   imem_loader #(.ADDR_W(32), .DEPTH(DEPTH), .BASE_ADDR(BASE)) dut (
      .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_data(in_data),
      .in_ready(in_ready), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .cpu_hold(cpu_hold), .busy(busy), .done(done), .error(error), .byte_count(byte_count)
   );

   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;
   int we_count = 0;

   always @(negedge clk) if (mem_we === 1'b1) we_count++;

   typedef struct {
      logic [31:0] len;
      bit          fixed;
      logic [7:0]  delta;
      int          maxgap;
      bit          start_mid;
      bit          exp_done;
      bit          exp_err;
   } vec_t;

   vec_t       tbl[11];
   logic [7:0] case2[8];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   // Called at a negedge; returns at the negedge following acceptance.
   task automatic send_byte(input logic [7:0] b, input int gap, input bit is_pay,
                            input logic [31:0] k);
      int t;
      in_valid = 1'b0;
      repeat (gap) @(negedge clk);
      in_valid = 1'b1;
      in_data  = b;
      t = 0;
      while (in_ready !== 1'b1 && t < 20) begin
         @(negedge clk);
         t++;
      end
      if (in_ready !== 1'b1) begin
         chk("accept_timeout", 32'(in_ready), 32'd1);
         in_valid = 1'b0;
         return;
      end
      @(negedge clk);
      in_valid = 1'b0;
      if (is_pay) begin
         chk("write_we", 32'(mem_we), 32'd1);
         chk("write_addr", mem_addr, BASE + k);
         chk("write_data", 32'(mem_wdata), 32'(b));
      end else begin
         chk("no_write", 32'(mem_we), 32'd0);
      end
   endtask

   task automatic pulse_start();
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic run_frame(input logic [31:0] len, input bit fixed, input logic [7:0] delta,
                            input int maxgap, input bit start_mid,
                            input bit exp_done, input bit exp_err);
      logic [7:0]  pay[$];
      logic [7:0]  sum, cs;
      logic [31:0] l;
      bit          hdr_ok;
      pay.delete();
      sum    = 8'd0;
      hdr_ok = !(len > DEPTH || len % 4 != 0);
      if (hdr_ok)
         for (int k = 0; k < int'(len); k++) begin
            pay.push_back(fixed ? case2[k % 8] : 8'($urandom));
            sum = sum + pay[k];
         end
      cs = 8'(256 - int'(sum)) + delta;
      l  = len;
      @(negedge clk);
      pulse_start();
      we_count = 0;
      chk("start_hold", 32'(cpu_hold), 32'd1);
      chk("start_busy", 32'(busy), 32'd1);
      chk("start_done", 32'(done), 32'd0);
      chk("start_err", 32'(error), 32'd0);
      chk("start_count", byte_count, 32'd0);
      for (int i = 0; i < 4; i++)
         send_byte(l[31-8*i -: 8], $urandom_range(maxgap, 0), 1'b0, 32'd0);
      if (hdr_ok) begin
         for (int k = 0; k < int'(len); k++) begin
            if (start_mid && k == int'(len) / 2) pulse_start();
            send_byte(pay[k], $urandom_range(maxgap, 0), 1'b1, 32'(k));
         end
         send_byte(cs, $urandom_range(maxgap, 0), 1'b0, 32'd0);
      end
      @(negedge clk);
      chk("end_done", 32'(done), 32'(exp_done));
      chk("end_err", 32'(error), 32'(exp_err));
      chk("end_hold", 32'(cpu_hold), 32'(!exp_done));
      chk("end_busy", 32'(busy), 32'd0);
      chk("end_ready", 32'(in_ready), 32'd0);
      chk("end_count", byte_count, hdr_ok ? len : 32'd0);
      chk("write_total", 32'(we_count), hdr_ok ? len : 32'd0);
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = 8'h00;
      case2 = '{8'h00, 8'h50, 8'h00, 8'h93, 8'h00, 8'h00, 8'h00, 8'h13};

      // len, fixed, delta, maxgap, start_mid, done, err
      tbl[0]  = '{32'd8,          1'b1, 8'h00, 0, 1'b0, 1'b1, 1'b0};
      tbl[1]  = '{32'd8,          1'b1, 8'h01, 0, 1'b0, 1'b0, 1'b1};
      tbl[2]  = '{32'h0000_1004,  1'b0, 8'h00, 0, 1'b0, 1'b0, 1'b1};
      tbl[3]  = '{32'd6,          1'b0, 8'h00, 0, 1'b0, 1'b0, 1'b1};
      tbl[4]  = '{32'd8,          1'b1, 8'h00, 5, 1'b0, 1'b1, 1'b0};
      tbl[5]  = '{32'd0,          1'b0, 8'h00, 1, 1'b0, 1'b1, 1'b0};
      tbl[6]  = '{32'd0,          1'b0, 8'h01, 0, 1'b0, 1'b0, 1'b1};
      tbl[7]  = '{32'd4096,       1'b0, 8'h00, 0, 1'b0, 1'b1, 1'b0};
      tbl[8]  = '{32'd4097,       1'b0, 8'h00, 0, 1'b0, 1'b0, 1'b1};
      tbl[9]  = '{32'd12,         1'b0, 8'h80, 3, 1'b0, 1'b0, 1'b1};
      tbl[10] = '{32'd8,          1'b1, 8'h00, 1, 1'b1, 1'b1, 1'b0};

      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_ready", 32'(in_ready), 32'd0);
      chk("rst_we", 32'(mem_we), 32'd0);
      chk("rst_addr", mem_addr, 32'd0);
      chk("rst_wdata", 32'(mem_wdata), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_err", 32'(error), 32'd0);
      chk("rst_count", byte_count, 32'd0);
      chk("rst_hold", 32'(cpu_hold), 32'd1);
      rst = 1'b0;

      for (int i = 0; i < 11; i++)
         run_frame(tbl[i].len, tbl[i].fixed, tbl[i].delta, tbl[i].maxgap,
                   tbl[i].start_mid, tbl[i].exp_done, tbl[i].exp_err);

      // Byte offered together with start from IDLE must not be consumed.
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      start = 1'b1; in_valid = 1'b1; in_data = 8'hFF;
      chk("idle_ready", 32'(in_ready), 32'd0);
      @(negedge clk);
      start = 1'b0; in_valid = 1'b0;
      for (int i = 0; i < 4; i++) send_byte(i == 3 ? 8'h08 : 8'h00, 0, 1'b0, 32'd0);
      for (int k = 0; k < 8; k++) send_byte(case2[k], 0, 1'b1, 32'(k));
      send_byte(8'h0A, 0, 1'b0, 32'd0);
      chk("nosteal_done", 32'(done), 32'd1);
      chk("nosteal_count", byte_count, 32'd8);

      // Start in DONE re-asserts cpu_hold on the next cycle.
      pulse_start();
      chk("restart_hold", 32'(cpu_hold), 32'd1);
      chk("restart_done", 32'(done), 32'd0);

      // Reset after three payload bytes, then a clean load.
      for (int i = 0; i < 4; i++) send_byte(i == 3 ? 8'h08 : 8'h00, 0, 1'b0, 32'd0);
      for (int k = 0; k < 3; k++) send_byte(case2[k], 0, 1'b1, 32'(k));
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("midrst_hold", 32'(cpu_hold), 32'd1);
      chk("midrst_busy", 32'(busy), 32'd0);
      chk("midrst_ready", 32'(in_ready), 32'd0);
      chk("midrst_we", 32'(mem_we), 32'd0);
      chk("midrst_count", byte_count, 32'd0);
      run_frame(32'd8, 1'b1, 8'h00, 0, 1'b0, 1'b1, 1'b0);

      // Random frames against the frame-level model.
      for (int n = 0; n < 25; n++) begin
         logic [31:0] len;
         logic [7:0]  delta;
         int          r;
         bit          ok, good;
         r = $urandom_range(9, 0);
         if (r < 7)       len = 32'(4 * $urandom_range(16, 0));
         else if (r == 7) len = 32'($urandom_range(40, 1));
         else             len = DEPTH + 32'(4 * $urandom_range(8, 1));
         delta = ($urandom_range(3, 0) == 0) ? 8'($urandom_range(255, 1)) : 8'h00;
         ok    = (len <= DEPTH) && (len % 4 == 0);
         // Frame checks out iff payload sum plus CS is 0 mod 256; CS = (-sum + delta).
         good  = ok && ((256 + int'(delta)) % 256 == 0);
         run_frame(len, 1'b0, delta, $urandom_range(3, 0), 1'b0, good, !good);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL global_timeout actual=running required=finished");
      $fatal(1);
   end

endmodule
